pkt_merge_pad: RTL and testbench
================================

Name: pkt_merge_pad

Overview:
Successor to the two-FIFO 4K fill stage. Merges NCH variable-length record streams into fixed-size output packets of PKT_WORDS words each. Channels are served round-robin, one whole record per grant. A record is never split across a packet boundary: if it does not fit, the current packet is padded with PAD_WORD up to the boundary first. The block sits between the per-PU result FIFOs and the host-DMA write FIFO, and supports downstream backpressure.

Parameters:
NCH, 4, number of input channels (2..16)
DW, 64, data word width
PKT_WORDS, 512, words per output packet (power of two, 4 KB at DW=64)
LEN_W, 10, width of the length field in a record header word; equals log2(PKT_WORDS)+1
PAD_WORD, 64'hFFFF_FFFF_FFFF_FFFF, filler word
IDLE_TIMEOUT, 256, idle cycles before a partial packet is flushed (used only with the optional feature)

Ports:
core_clk  in  1  clock
core_rst_n  in  1  async active-low reset
ch_vld  in  NCH  per-channel word valid
ch_data  in  NCH*DW  per-channel word; channel i occupies bits [i*DW +: DW]
ch_eop  in  NCH  last word of the record
ch_rdy  out  NCH  word accepted on this channel when ch_vld&ch_rdy
out_vld  out  1  output word valid
out_data  out  DW  output word
out_pad  out  1  current output word is filler
out_eop  out  1  last word of a packet
out_rdy  in  1  downstream accepts the word when out_vld&out_rdy
err_len  out  1  sticky: a header had len==0 or len>PKT_WORDS
pkt_cnt  out  32  count of completed packets (wraps)

Behaviour:
- Clock and reset: one clock, core_clk; reset is asynchronous, active-low (core_rst_n).
- Reset values: all outputs 0 except out_data=PAD_WORD. Internal state: FSM=IDLE, word_cnt=0, rr_ptr=0.
- Record format: first word is the header; len=hdr[LEN_W-1:0] = total record words including the header. The header is forwarded unchanged. ch_eop marks the last word.
- Output stage: a single register. It advances when adv = !out_vld | out_rdy. out_vld/out_data/out_pad/out_eop are held while out_vld & !out_rdy.
- ch_rdy[i] = (state==XFER | state==CHECK-accept) & grant==i & adv. It is combinational from out_rdy and at most one bit is high.
- word_cnt (width log2 PKT_WORDS) increments on every output-stage load. out_eop=1 when the loaded word has word_cnt==PKT_WORDS-1; word_cnt then wraps to 0 and pkt_cnt increments on that word's handshake.
- FSM:
  - IDLE: pick the first i with ch_vld[i], searching from rr_ptr upward with wrap, then go to CHECK with grant=i. Stay in IDLE if no channel is valid.
  - CHECK: compute rem = PKT_WORDS - word_cnt, using LEN_W-bit arithmetic. If len<=rem, go to XFER without consuming the header. Otherwise go to PAD.
  - PAD: load PAD_WORD with out_pad=1 on each adv until the word with out_eop is loaded, then go to XFER. No channel is popped during PAD.
  - XFER: pass the granted channel's words on ch_vld&ch_rdy. On the word with ch_eop, set rr_ptr=grant+1 (mod NCH) and go to IDLE. A channel bubble (ch_vld low) inserts no output word.
- Oversize or zero length (len>PKT_WORDS or len==0): set err_len. The record is forwarded without pre-padding and may span packets; ch_eop alone terminates it.
- A record that exactly fills a packet (len==rem) goes to XFER with no pad word.
- If ch_eop arrives earlier or later than len indicates, the block follows ch_eop and ignores len for termination.
- Reset asserted mid-packet drops all state immediately; the partial packet is discarded.
- Throughput: 1 word/cycle when out_rdy=1. IDLE→CHECK→XFER adds 2 bubble cycles per record.

Optional Feature:
MERGE_IDLE_FLUSH_EN
- With the macro defined: in IDLE with word_cnt!=0, an idle counter increments each cycle no ch_vld bit is set, and resets when any bit is set. On reaching IDLE_TIMEOUT the FSM enters PAD, completing the partial packet, then returns to IDLE instead of XFER. A channel going valid during this flush PAD waits until the flush completes.
- Without the macro: no counter is built, and a partial packet is held until later records fill it.

Test Plan:
- NCH=2, PKT_WORDS=16. Ch0 sends a len=5 record, then ch1 a len=5 record, out_rdy=1 → 10 data words in order ch0 then ch1, word_cnt=10, no out_eop, pkt_cnt=0.
- Continue with a ch0 len=8 record (rem=6) → 6 PAD_WORD words with out_pad=1, out_eop on the 6th, pkt_cnt=1, then 8 ch0 words starting at word_cnt=0.
- All 4 channels continuously valid, each sending len=2 records → grants 0,1,2,3,0,… with no channel granted twice in a row.
- len==rem exact fill (len=16 at word_cnt=0) → out_eop on the record's last word, zero pad words.
- Header len=20 > PKT_WORDS → err_len=1, all 20 words forwarded across the packet boundary, out_eop at word 16, no padding.
- out_rdy toggled randomly 50% during XFER and PAD → output word sequence identical to the out_rdy=1 run; no word lost or duplicated. With MERGE_IDLE_FLUSH_EN and IDLE_TIMEOUT=8, idle after word_cnt=3 → PAD starts 8 cycles later and pads 13 words.

Source files
------------

// File: rtl/pkt_merge_pad.sv
// Merges NCH record streams round-robin into fixed PKT_WORDS-word packets, padding
// with PAD_WORD when a record would straddle a boundary. Optional: MERGE_IDLE_FLUSH_EN.

module pkt_merge_lane #(
  parameter int DW = 64
) (
  input  logic          sel,
  input  logic          xfer,
  input  logic          adv,
  input  logic          vld,
  input  logic          eop,
  input  logic [DW-1:0] data,
  output logic          rdy,
  output logic          m_vld,
  output logic          m_eop,
  output logic [DW-1:0] m_data
);
  // Unselected lanes contribute zeros so the top can OR-reduce them.
  assign rdy    = sel & xfer & adv;
  assign m_vld  = sel & vld;
  assign m_eop  = sel & eop;
  assign m_data = sel ? data : '0;
endmodule

module pkt_merge_pad #(
  parameter int             NCH          = 4,
  parameter int             DW           = 64,
  parameter int             PKT_WORDS    = 512,
  parameter int             LEN_W        = 10,
  parameter logic [DW-1:0]  PAD_WORD     = {DW{1'b1}},
  parameter int             IDLE_TIMEOUT = 256
) (
  input  logic              core_clk,
  input  logic              core_rst_n,
  input  logic [NCH-1:0]    ch_vld,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic [NCH-1:0]    ch_eop,
  output logic [NCH-1:0]    ch_rdy,
  output logic              out_vld,
  output logic [DW-1:0]     out_data,
  output logic              out_pad,
  output logic              out_eop,
  input  logic              out_rdy,
  output logic              err_len,
  output logic [31:0]       pkt_cnt
);
  localparam int WC_W = $clog2(PKT_WORDS);
  localparam int G_W  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, CHECK, PAD, XFER} state_t;

  state_t                  state, state_nxt;
  logic [G_W-1:0]          grant, grant_nxt, rr_ptr, rr_ptr_nxt;
  logic [WC_W-1:0]         word_cnt;
  logic                    adv, xfer, load, load_pad, set_err, last_slot;
  logic                    found;
  int                      pick;

  logic [NCH-1:0][DW-1:0]  ch_w;
  logic [NCH-1:0]          lane_sel, lane_vld, lane_eop;
  logic [NCH-1:0][DW-1:0]  lane_data;
  logic                    sel_vld, sel_eop;
  logic [DW-1:0]           sel_data;
  logic [LEN_W-1:0]        hdr_len, rem;
  logic                    len_bad;

  assign ch_w = ch_data;
  assign adv  = !out_vld | out_rdy;
  assign xfer = (state == XFER);

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    assign lane_sel[i] = (grant == G_W'(i));
    pkt_merge_lane #(.DW(DW)) u_lane (
      .sel    (lane_sel[i]),
      .xfer   (xfer),
      .adv    (adv),
      .vld    (ch_vld[i]),
      .eop    (ch_eop[i]),
      .data   (ch_w[i]),
      .rdy    (ch_rdy[i]),
      .m_vld  (lane_vld[i]),
      .m_eop  (lane_eop[i]),
      .m_data (lane_data[i])
    );
  end

  assign sel_vld = |lane_vld;
  assign sel_eop = |lane_eop;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NCH; i++) sel_data = sel_data | lane_data[i];
  end

  // Fit check uses LEN_W-bit arithmetic so rem == PKT_WORDS is representable.
  assign hdr_len   = sel_data[LEN_W-1:0];
  assign len_bad   = (hdr_len == '0) || (hdr_len > LEN_W'(PKT_WORDS));
  assign rem       = LEN_W'(PKT_WORDS) - LEN_W'(word_cnt);
  assign last_slot = (word_cnt == WC_W'(PKT_WORDS - 1));

`ifdef MERGE_IDLE_FLUSH_EN
  localparam int IC_W = $clog2(IDLE_TIMEOUT + 1);
  logic [IC_W-1:0] idle_cnt;
  logic            flush, flush_nxt;

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      idle_cnt <= '0;
      flush    <= 1'b0;
    end else begin
      flush <= flush_nxt;
      if (state == IDLE && word_cnt != '0 && ch_vld == '0)
        idle_cnt <= idle_cnt + 1'b1;
      else
        idle_cnt <= '0;
    end
  end
`endif

  always_comb begin
    found = 1'b0;
    pick  = 0;
    for (int k = 0; k < NCH; k++) begin
      if (!found && ch_vld[(int'(rr_ptr) + k) % NCH]) begin
        found = 1'b1;
        pick  = (int'(rr_ptr) + k) % NCH;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    load       = 1'b0;
    load_pad   = 1'b0;
    set_err    = 1'b0;
`ifdef MERGE_IDLE_FLUSH_EN
    flush_nxt  = flush;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = G_W'(pick);
          state_nxt = CHECK;
        end
`ifdef MERGE_IDLE_FLUSH_EN
        else if (word_cnt != '0 && idle_cnt == IC_W'(IDLE_TIMEOUT - 1)) begin
          state_nxt = PAD;
          flush_nxt = 1'b1;
        end
`endif
      end
      CHECK: begin
        if (sel_vld) begin
          if (len_bad) begin
            set_err   = 1'b1;
            state_nxt = XFER;
          end else if (hdr_len <= rem) begin
            state_nxt = XFER;
          end else begin
            state_nxt = PAD;
          end
        end
      end
      PAD: begin
        if (adv) begin
          load     = 1'b1;
          load_pad = 1'b1;
          if (last_slot) begin
`ifdef MERGE_IDLE_FLUSH_EN
            state_nxt = flush ? IDLE : XFER;
            flush_nxt = 1'b0;
`else
            state_nxt = XFER;
`endif
          end
        end
      end
      XFER: begin
        // ch_eop alone ends the record; the header length is not consulted here.
        if (adv && sel_vld) begin
          load = 1'b1;
          if (sel_eop) begin
            rr_ptr_nxt = (grant == G_W'(NCH - 1)) ? '0 : grant + 1'b1;
            state_nxt  = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      out_vld  <= 1'b0;
      out_data <= PAD_WORD;
      out_pad  <= 1'b0;
      out_eop  <= 1'b0;
      word_cnt <= '0;
      err_len  <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      if (load) begin
        out_vld  <= 1'b1;
        out_data <= load_pad ? PAD_WORD : sel_data;
        out_pad  <= load_pad;
        out_eop  <= last_slot;
        word_cnt <= word_cnt + 1'b1;
      end else if (adv) begin
        out_vld <= 1'b0;
        out_pad <= 1'b0;
        out_eop <= 1'b0;
      end
      if (set_err) err_len <= 1'b1;
      if (out_vld && out_rdy && out_eop) pkt_cnt <= pkt_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pkt_merge_pad.sv
// Scoreboard bench for pkt_merge_pad: a packet model predicts every output word,
// which is compared on each out_vld&out_rdy handshake.

module tb_pkt_merge_pad;
  localparam int NCH = 4;
  localparam int DW  = 64;
  localparam int PKT = 16;
  localparam int LW  = 5;
  localparam logic [DW-1:0] PADW = {DW{1'b1}};

  logic              core_clk, core_rst_n;
  logic [NCH-1:0]    ch_vld, ch_eop, ch_rdy;
  logic [NCH*DW-1:0] ch_data;
  logic              out_vld, out_pad, out_eop, out_rdy, err_len;
  logic [DW-1:0]     out_data;
  logic [31:0]       pkt_cnt;

  pkt_merge_pad #(.NCH(NCH), .DW(DW), .PKT_WORDS(PKT), .LEN_W(LW),
                  .PAD_WORD(PADW), .IDLE_TIMEOUT(8)) u_dut (
    .core_clk   (core_clk),
    .core_rst_n (core_rst_n),
    .ch_vld     (ch_vld),
    .ch_data    (ch_data),
    .ch_eop     (ch_eop),
    .ch_rdy     (ch_rdy),
    .out_vld    (out_vld),
    .out_data   (out_data),
    .out_pad    (out_pad),
    .out_eop    (out_eop),
    .out_rdy    (out_rdy),
    .err_len    (err_len),
    .pkt_cnt    (pkt_cnt)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  typedef struct packed { logic [DW-1:0] d; logic e; } cw_t;
  typedef struct packed { logic [DW-1:0] d; logic p; logic e; } ow_t;

  cw_t chq [NCH][$];
  ow_t expq[$];
  int  p_len[NCH][$], p_n[NCH][$], p_seq[NCH][$];
  int  n_chk = 0, n_err = 0;
  int  m_wc, m_rr, m_pkt, seq_ctr;
  bit  m_err, bp_en;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkword(int ch, int seq, int j, int len);
    logic [DW-1:0] w;
    w = {4'hA, 4'(ch), 16'(seq), 8'(j), 32'h0};
    w[31:8] = 24'(seq * 7 + j * 13 + ch);
    if (j == 0) w[7:0] = 8'(len & ((1 << LW) - 1));
    else        w[7:0] = 8'(j * 3 + 1);
    return w;
  endfunction

  task automatic push_exp(input logic [DW-1:0] d, input logic p);
    ow_t o;
    o.d = d; o.p = p; o.e = (m_wc == PKT - 1);
    expq.push_back(o);
    if (o.e) m_pkt++;
    m_wc = (m_wc + 1) % PKT;
  endtask

  task automatic model_rec(input int ch, input int seq, input int len, input int n);
    bit bad;
    int rem;
    bad = (len == 0) || (len > PKT);
    rem = PKT - m_wc;
    if (bad) m_err = 1;
    else if (len > rem) repeat (rem) push_exp(PADW, 1'b1);
    for (int j = 0; j < n; j++) push_exp(mkword(ch, seq, j, len), 1'b0);
  endtask

  task automatic add(input int ch, input int len, input int n);
    p_len[ch].push_back(len);
    p_n[ch].push_back(n);
    p_seq[ch].push_back(seq_ctr++);
  endtask

  // All pending records go live in one step; the model replays round-robin order.
  task automatic run_batch(input string tag);
    cw_t w;
    int  idx[NCH];
    int  left, cyc, ch;
    bit  busy;
    @(posedge core_clk);
    left = 0;
    for (int c = 0; c < NCH; c++) begin
      idx[c] = 0;
      left += p_n[c].size();
      for (int r = 0; r < p_n[c].size(); r++)
        for (int j = 0; j < p_n[c][r]; j++) begin
          w.d = mkword(c, p_seq[c][r], j, p_len[c][r]);
          w.e = (j == p_n[c][r] - 1);
          chq[c].push_back(w);
        end
    end
    while (left > 0) begin
      ch = -1;
      for (int k = 0; k < NCH; k++)
        if (ch < 0 && idx[(m_rr + k) % NCH] < p_n[(m_rr + k) % NCH].size()) ch = (m_rr + k) % NCH;
      model_rec(ch, p_seq[ch][idx[ch]], p_len[ch][idx[ch]], p_n[ch][idx[ch]]);
      idx[ch]++;
      left--;
      m_rr = (ch + 1) % NCH;
    end
    for (int c = 0; c < NCH; c++) begin
      p_len[c].delete(); p_n[c].delete(); p_seq[c].delete();
    end
    cyc = 0;
    busy = 1;
    while (busy && cyc < 3000) begin
      @(negedge core_clk);
      cyc++;
      busy = (expq.size() != 0);
      for (int c = 0; c < NCH; c++) if (chq[c].size() != 0) busy = 1;
    end
    chk({tag, "_drain"}, expq.size(), 0);
    expq.delete();
    for (int c = 0; c < NCH; c++) chq[c].delete();
    repeat (3) @(negedge core_clk);
    chk({tag, "_pkt_cnt"}, pkt_cnt, m_pkt);
    chk({tag, "_err_len"}, err_len, m_err);
    chk({tag, "_word_cnt"}, u_dut.word_cnt, m_wc);
  endtask

  // Drive at negedge, then check the handshakes that the next posedge will take.
  initial begin
    ow_t e;
    ch_vld = '0; ch_data = '0; ch_eop = '0; out_rdy = 1'b0;
    forever begin
      @(negedge core_clk);
      for (int i = 0; i < NCH; i++) begin
        if (chq[i].size() > 0) begin
          ch_vld[i] = 1'b1;
          ch_data[i*DW +: DW] = chq[i][0].d;
          ch_eop[i] = chq[i][0].e;
        end else begin
          ch_vld[i] = 1'b0;
          ch_data[i*DW +: DW] = '0;
          ch_eop[i] = 1'b0;
        end
      end
      out_rdy = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (core_rst_n) begin
        if (out_vld && out_rdy) begin
          if (expq.size() == 0) chk("extra_word", 1, 0);
          else begin
            e = expq.pop_front();
            chk("out_word", {out_data, out_pad, out_eop}, {e.d, e.p, e.e});
          end
        end
        if (ch_rdy != '0) chk("rdy_onehot", $onehot(ch_rdy), 1);
        for (int i = 0; i < NCH; i++)
          if (ch_vld[i] && ch_rdy[i]) void'(chq[i].pop_front());
      end
    end
  end

  task automatic do_reset();
    core_rst_n = 1'b0;
    m_wc = 0; m_rr = 0; m_pkt = 0; m_err = 0;
    repeat (3) @(negedge core_clk);
    #2;
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_data", out_data, PADW);
    chk("rst_out_pad", out_pad, 0);
    chk("rst_out_eop", out_eop, 0);
    chk("rst_err_len", err_len, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_ch_rdy", ch_rdy, 0);
    chk("rst_word_cnt", u_dut.word_cnt, 0);
    @(negedge core_clk);
    core_rst_n = 1'b1;
  endtask

  initial begin
    bp_en = 0;
    seq_ctr = 1;
    do_reset();

    add(0, 5, 5); add(1, 5, 5);
    run_batch("two_rec");
    add(0, 8, 8);
    run_batch("pad6");
    for (int r = 0; r < 2; r++) for (int c = 0; c < NCH; c++) add(c, 2, 2);
    run_batch("rr4");
    add(2, 16, 16);
    run_batch("pad_full");
    add(3, 16, 16);
    run_batch("exact_fill");
    add(1, 20, 20);
    run_batch("oversize");

    bp_en = 1;
    add(0, 6, 3); add(1, 13, 13); add(2, 3, 5); add(3, 7, 7);
    add(0, 4, 4); add(2, 0, 2);
    run_batch("bp_mix");
    for (int r = 0; r < 3; r++) for (int c = 0; c < NCH; c++) add(c, 3 + c, 3 + c);
    add(1, 9, 9);
    run_batch("bp_rr");
    bp_en = 0;

    add(0, 7, 7);
    run_batch("pre_reset");
    do_reset();
    add(1, 16, 16); add(0, 16, 16);
    run_batch("post_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
